// File: rtl/shift_register.sv
// Serial-in / serial-out shift register with a parallel view of its contents.
// Ports:
//   clk         - rising-edge clock, the only clock of the block
//   reset       - synchronous reset, active low (0 = reset)
//   data_in     - serial input bit, sampled on the rising edge of clk
//   data_out    - serial output, the bit about to leave the register
//   reg_content - current register contents
//   fill_cnt    - bits shifted in since reset, saturates at WIDTH
//   full        - 1 once WIDTH bits have been shifted in since reset
module shift_register #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter bit                 SHIFT_MSB = 1'b1,
    localparam int                CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    output logic             data_out,
    output logic [WIDTH-1:0] reg_content,
    output logic [CW-1:0]    fill_cnt,
    output logic             full
);

    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    r_cnt;
    logic             r_full;
    logic [WIDTH-1:0] w_next;

    // Direction is fixed at elaboration, so only one shifter is built.
    generate
        if (SHIFT_MSB) begin : g_msb
            assign w_next = {r_reg[WIDTH-2:0], data_in};
        end else begin : g_lsb
            assign w_next = {data_in, r_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_reg  <= RESET_VAL;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            r_reg <= w_next;
            // Count stops at WIDTH; full tracks the count reaching WIDTH
            // on this edge so it never lags fill_cnt.
            if (!r_full) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_full <= 1'b1;
            end
        end
    end

    assign data_out    = SHIFT_MSB ? r_reg[WIDTH-1] : r_reg[0];
    assign reg_content = r_reg;
    assign fill_cnt    = r_cnt;
    assign full        = r_full;

endmodule

// File: tb/tb_shift_register.sv
// Bench for shift_register: a 4-bit MSB-shifting and an 8-bit LSB-shifting
// instance fed the same stream, compared against a queue-based model.
module tb_shift_register;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       data_in = 1'b0;

    logic       a_dout;
    logic [3:0] a_reg;
    logic [2:0] a_cnt;
    logic       a_full;

    logic       b_dout;
    logic [7:0] b_reg;
    logic [3:0] b_cnt;
    logic       b_full;

    int n_total = 0;
    int n_pass  = 0;

    // Every bit accepted since the most recent reset, oldest first.
    bit hist[$];

    always #5 clk = ~clk;

    shift_register #(.WIDTH(4), .SHIFT_MSB(1'b1)) u_a (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_out(a_dout), .reg_content(a_reg),
        .fill_cnt(a_cnt), .full(a_full)
    );

    shift_register #(.WIDTH(8), .SHIFT_MSB(1'b0)) u_b (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_out(b_dout), .reg_content(b_reg),
        .fill_cnt(b_cnt), .full(b_full)
    );

    // The k-th most recent bit sits k places from the entry end.
    function automatic logic [63:0] exp_word(int w, bit msb);
        logic [63:0] v;
        int n;
        v = '0;
        n = hist.size();
        for (int k = 0; k < w && k < n; k++) begin
            if (msb) v[k] = hist[n-1-k];
            else     v[w-1-k] = hist[n-1-k];
        end
        return v;
    endfunction

    // Bit applied w edges ago, or 0 if fewer than w bits since reset.
    function automatic logic exp_out(int w);
        int n;
        n = hist.size();
        return (n >= w) ? hist[n-w] : 1'b0;
    endfunction

    function automatic logic [63:0] exp_cnt(int w);
        return (hist.size() < w) ? 64'(hist.size()) : 64'(w);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(string tag);
        chk({tag, " a_reg"},  64'(a_reg), exp_word(4, 1'b1));
        chk({tag, " a_dout"}, 64'(a_dout), 64'(exp_out(4)));
        chk({tag, " a_cnt"},  64'(a_cnt), exp_cnt(4));
        chk({tag, " a_full"}, 64'(a_full), 64'(hist.size() >= 4));
        chk({tag, " b_reg"},  64'(b_reg), exp_word(8, 1'b0));
        chk({tag, " b_dout"}, 64'(b_dout), 64'(exp_out(8)));
        chk({tag, " b_cnt"},  64'(b_cnt), exp_cnt(8));
        chk({tag, " b_full"}, 64'(b_full), 64'(hist.size() >= 8));
    endtask

    task automatic step(string tag, bit rst_n, bit d);
        reset   = rst_n;
        data_in = d;
        @(posedge clk);
        if (!rst_n) begin
            hist.delete();
        end else begin
            hist.push_back(d);
            if (hist.size() > 16) void'(hist.pop_front());
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] pat;

        // Reset for two edges
        step("rst0", 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b0);
        chk("rst a_reg lit", 64'(a_reg), 64'h0);

        // Fill with 1,0,1,1
        step("fill0", 1'b1, 1'b1);
        chk("fill0 lit", 64'(a_reg), 64'h1);
        step("fill1", 1'b1, 1'b0);
        chk("fill1 lit", 64'(a_reg), 64'h2);
        step("fill2", 1'b1, 1'b1);
        chk("fill2 lit", 64'(a_reg), 64'h5);
        step("fill3", 1'b1, 1'b1);
        chk("fill3 lit", 64'(a_reg), 64'hB);
        chk("fill3 full lit", 64'(a_full), 64'h1);

        // Continue 0,1,0,1
        step("cont0", 1'b1, 1'b0);
        step("cont1", 1'b1, 1'b1);
        step("cont2", 1'b1, 1'b0);
        step("cont3", 1'b1, 1'b1);
        chk("cont lit", 64'(a_reg), 64'h5);

        // Mid-stream reset, then 1,1,1,1
        step("mid_rst", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("ones", 1'b1, 1'b1);
        chk("ones lit", 64'(a_reg), 64'hF);

        // Held reset with toggling input
        for (int i = 0; i < 6; i++) step("hold", 1'b0, 1'(i));

        // 8'hA5 LSB-first into the 8-bit LSB-shifting instance
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) step("a5", 1'b1, pat[i]);
        chk("a5 lit", 64'(b_reg), 64'hA5);
        chk("a5 full lit", 64'(b_full), 64'h1);

        // Random stream with occasional resets; saturation is exercised
        // by long runs between resets.
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 19) != 0), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
